booth_mul_seq: RTL

- Iterative radix-4 Booth multiplier controller. It sequences a single-digit Booth partial-product selector plus a shared accumulator over successive cycles.
- Retires one Booth digit per cycle, selecting from {0, +X, +2X, -X, -2X}, and produces an exact double-width product.
- Sits between the integer execute stage and its result bus as a multi-cycle functional unit with valid/ready handshakes on both sides.

---
 rtl/booth_mul_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier.
// Accepts one operand pair through a valid/ready handshake, retires one Booth
// digit per cycle into a guarded accumulator, then presents the exact
// double-width product until the consumer takes it.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    // Accumulator carries two guard bits above the product so the transient
    // overflow of the corner operands (-2^(WIDTH-1), all-ones) wraps harmlessly.
    localparam int ACC_W = 2 * WIDTH + 2;
    // Wide enough to hold the largest digit index (WIDTH/2 in unsigned mode).
    localparam int CW    = $clog2(WIDTH / 2 + 2);
    // Wide enough to hold the largest shift amount, 2*(WIDTH/2) = WIDTH.
    localparam int SW    = $clog2(ACC_W);
    // Selected multiple of the multiplicand: 2*Xe needs one bit more than Xe.
    localparam int SEL_W = WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   xe_q, xe_d;     // extended multiplicand
    logic [WIDTH+2:0]   ye_q, ye_d;     // extended multiplier with y[-1] appended
    logic [ACC_W-1:0]   acc_q, acc_d;   // running sum of shifted partial products
    logic [CW-1:0]      cnt_q, cnt_d;   // index of the digit retired this cycle
    logic [CW-1:0]      last_q, last_d; // index of the final digit (mode dependent)

    // Datapath intermediates for the current digit.
    logic [SW-1:0]      shamt;
    logic [WIDTH+2:0]   ye_shifted;
    logic [2:0]         triplet;
    logic [SEL_W-1:0]   sel;
    logic               neg;
    logic [SEL_W-1:0]   pp_raw;
    logic [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]   pp_shifted;
    logic [ACC_W-1:0]   carry_in;
    logic [ACC_W-1:0]   acc_sum;
    logic               accept;

    // Booth digit selection and accumulation for the digit at cnt_q.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave a value held and infer a latch.
        sel        = '0;
        neg        = 1'b0;
        shamt      = SW'(cnt_q) << 1;
        ye_shifted = ye_q >> shamt;
        triplet    = ye_shifted[2:0];

        unique case (triplet)
            3'b001, 3'b010: sel = {xe_q[WIDTH+1], xe_q};
            3'b011:         sel = {xe_q, 1'b0};
            3'b100:         begin sel = {xe_q, 1'b0};            neg = 1'b1; end
            3'b101, 3'b110: begin sel = {xe_q[WIDTH+1], xe_q};   neg = 1'b1; end
            default:        sel = '0; // 000, 111: zero digit
        endcase

        // Negation: one's complement here, the +1 enters as a carry at bit 2i,
        // so the whole step is a single add with no correction pass.
        pp_raw     = neg ? ~sel : sel;
        pp_ext     = {{(ACC_W - SEL_W){pp_raw[SEL_W-1]}}, pp_raw};
        pp_shifted = pp_ext << shamt;
        carry_in   = ACC_W'(neg) << shamt;
        acc_sum    = acc_q + pp_shifted + carry_in;
    end

    assign accept = in_valid && (state_q == ST_IDLE);

    // Next-state and register-load control for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    xe_d    = signed_mode ? {{2{X[WIDTH-1]}}, X} : {2'b00, X};
                    ye_d    = {{2{signed_mode & Y[WIDTH-1]}}, Y, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    // Unsigned needs one extra digit to consume the zero
                    // extension that makes the top Booth digit non-negative.
                    last_d  = signed_mode ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        // NOTE: the datapath registers are reset too: P is defined as zero
        // during reset and an aborted operation must leave no residue.
        if (rst) begin
            state_q <= ST_IDLE;
            xe_q    <= '0;
            ye_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    // The accumulator is untouched in DONE and IDLE, so P is stable while
    // out_valid is high and keeps its value after the handshake.
    assign P         = acc_q[2*WIDTH-1:0];

endmodule
